spi_packet_tx: RTL
==================

Name: spi_packet_tx

Overview:
- SPI master transmitter that builds the two-byte paint-link packets (configuration or cursor position) and shifts them out on the serial link.
- This is the sending end of the packet format the FPGA's packet decoder consumes.
- Sits between the local control/cursor logic and the SPI pins. Used in loopback benches and for FPGA-to-FPGA links.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period; legal range >= 1.
- GAP_CYCLES, 8, minimum clk cycles cs_n stays high between frames; legal range >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request to send one packet
- req_ready  output  1  high only in IDLE; a transfer is accepted on req_valid && req_ready at a clk edge
- req_conf  input  1  1 = configuration packet, 0 = position packet
- brush  input  1  brush enable (config packets)
- color  input  3  colour index (config packets)
- x  input  8  cursor x (position packets)
- y  input  8  cursor y (position packets)
- sck  output  1  SPI clock, mode 0, idles low
- cs_n  output  1  frame select, active low
- mosi  output  1  serial data, MSB first
- busy  output  1  high from the cycle after accept until req_ready returns
- done  output  1  one-cycle pulse at frame end
- x_clamped  output  1  high for the whole frame if x was clamped

Behaviour:
- Encoding, latched at accept; input changes after accept are ignored. Frame word is 16 bits = {byte1, byte2}, byte1 sent first, MSB first.
- Config packet: byte1 = {3'b111, brush, 1'b0, color[2:0]}, byte2 = 8'h00.
- Position packet: byte1 = x, byte2 = y.
  - The 3'b111 prefix is reserved for config packets, so x >= 8'hE0 is sent as 8'hDF.
  - x_clamped is set for that frame; x_clamped is never set for config packets.
- FSM states: IDLE, SETUP, SHIFT, GAP.
- IDLE: cs_n=1, sck=0, req_ready=1, busy=0. On accept, go to SETUP.
- SETUP: lasts CLK_DIV cycles.
  - On the first cycle, cs_n=0 and mosi=bit15, registered.
  - On exit, sck rises and SHIFT begins.
- SHIFT: 16 bit periods, each = CLK_DIV cycles sck high, then CLK_DIV cycles sck low.
  - mosi changes only on sck falling edges, to the next bit.
  - After the 16th falling edge, mosi holds bit0 for CLK_DIV cycles of sck low (trailing hold), then cs_n goes high and the FSM enters GAP.
  - cs_n-low duration = 33*CLK_DIV cycles (132 at default).
  - Exactly 16 sck rising edges per frame; no sck edges while cs_n=1.
- GAP: cs_n=1, sck=0, mosi=0, req_ready=0. Lasts GAP_CYCLES cycles, then IDLE.
  - done pulses on the first GAP cycle only.
  - x_clamped clears when IDLE is entered.
- A bit counter (0..15) and a half-period counter (0..CLK_DIV-1) drive the FSM. The half-period counter is wide enough for CLK_DIV.
- All pin outputs (sck, cs_n, mosi) are registered, so there are no glitches.
- Back-to-back: with req_valid held high, the next accept occurs on the first IDLE cycle. Frames are separated by exactly GAP_CYCLES+1 cycles of cs_n high.
- req_valid while not ready is ignored; there is no queueing.
- Reset values, asserted asynchronously at any time, including mid-frame: state=IDLE, sck=0, cs_n=1, mosi=0, busy=0, done=0, x_clamped=0.
  - req_ready=1 once reset deasserts.
  - A frame aborted by reset is simply truncated; no done pulse.

Test Plan:
- Config: req_conf=1, brush=1, color=3'b101, CLK_DIV=4 -> cs_n low 132 cycles, 16 sck rises; sampled word 16'hF500; done pulse 1 cycle; x_clamped=0.
- Position: x=8'h3C, y=8'hA7 -> sampled 16'h3CA7. Changing x/y mid-frame does not alter the word.
- Clamp: x=8'hF0, y=8'h10 -> sampled 16'hDF10; x_clamped=1 throughout the frame, 0 in IDLE. x=8'hDF -> x_clamped=0.
- Back-to-back with req_valid held: two frames; cs_n high exactly GAP_CYCLES+1 cycles between them; no sck activity while cs_n high.
- Reset asserted after the 7th sck rise -> same cycle: cs_n=1, sck=0, mosi=0, busy=0. No done pulse. The next frame after reset is correct.
- CLK_DIV=1, GAP_CYCLES=1 -> sck toggles every cycle, cs_n low 33 cycles, word still correct.

Source files
------------

// File: rtl/spi_packet_tx.sv
// spi_packet_tx: SPI mode-0 master that encodes two-byte paint-link packets
// (configuration or cursor position) and shifts them out MSB first.
module spi_packet_tx #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_conf,
  input  logic       brush,
  input  logic [2:0] color,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic       sck,
  output logic       cs_n,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic       x_clamped
);

  localparam int unsigned HW = $clog2(CLK_DIV + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   half_q, half_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [3:0]      bit_q, bit_d;
  logic [14:0]     shreg_q, shreg_d;
  logic            sck_q, sck_d;
  logic            cs_n_q, cs_n_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            clamp_q, clamp_d;
  logic            ready_q, ready_d;

  logic [15:0]     word_c;
  logic            clamp_c;
  logic            half_end_c;

  // Packet encoding; x values colliding with the config prefix are clamped.
  always_comb begin
    clamp_c = !req_conf && (x >= 8'hE0);
    if (req_conf) begin
      word_c = {3'b111, brush, 1'b0, color, 8'h00};
    end else begin
      word_c = {(clamp_c ? 8'hDF : x), y};
    end
  end

  assign half_end_c = (half_q == HW'(CLK_DIV - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    clamp_d = clamp_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          mosi_d  = word_c[15];
          shreg_d = word_c[14:0];
          clamp_d = clamp_c;
          half_d  = '0;
          bit_d   = '0;
        end
      end
      SETUP: begin
        if (half_end_c) begin
          half_d  = '0;
          sck_d   = 1'b1;
          state_d = SHIFT;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      SHIFT: begin
        if (!half_end_c) begin
          half_d = half_q + HW'(1);
        end else begin
          half_d = '0;
          if (sck_q) begin
            // Falling edge: advance to the next bit, or hold bit0 after the last.
            sck_d = 1'b0;
            if (bit_q != 4'd15) begin
              mosi_d  = shreg_q[14];
              shreg_d = {shreg_q[13:0], 1'b0};
            end
          end else if (bit_q == 4'd15) begin
            // End of trailing hold: release the frame.
            state_d = GAP;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            gap_d   = '0;
          end else begin
            sck_d = 1'b1;
            bit_d = bit_q + 4'd1;
          end
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          clamp_d = 1'b0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      half_q  <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clamp_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clamp_q <= clamp_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign sck       = sck_q;
  assign cs_n      = cs_n_q;
  assign mosi      = mosi_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign x_clamped = clamp_q;

endmodule
